// File: rtl/field_edit_pkg.sv
// Shared definitions for the edit-mode controller and the timebase blocks:
// controller state encoding and time-to-cycle conversion helpers.
package field_edit_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_ARM  = 2'd1,
    ST_REL  = 2'd2,
    ST_EDIT = 2'd3
  } state_e;

  function automatic int unsigned ms_to_cycles(input int unsigned clk_hz,
                                               input int unsigned ms);
    return clk_hz / 1000 * ms;
  endfunction

  // Counter width able to hold max_count-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned max_count);
    return (max_count > 1) ? $clog2(max_count) : 1;
  endfunction

endpackage

// File: rtl/key_sync_edge.sv
// Two-flop synchroniser for the raw active-low key plus a one-cycle pulse on
// the synchronised press (1->0) edge.
module key_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic key_n_i,
  output logic level_o,
  output logic press_o
);

  logic s1_q, s2_q, prev_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: non-blocking assignments make all three flops sample the
      // pre-edge values, which is what turns them into a shift chain.
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      s1_q   <= key_n_i;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  assign level_o = s2_q;
  assign press_o = prev_q & ~s2_q;

endmodule

// File: rtl/field_edit_ctrl.sv
// Edit-mode controller: long press enters edit, short presses step through the
// fields, selected field flashes, idle timeout or last field returns to run.
module field_edit_ctrl
  import field_edit_pkg::*;
#(
  parameter int unsigned NFIELDS   = 3,
  parameter int unsigned CLK_HZ    = 50_000_000,
  parameter int unsigned HOLD_MS   = 1000,
  parameter int unsigned FLASH_MS  = 1000,
  parameter int unsigned OFF_MS    = 200,
  parameter int unsigned TIMEOUT_S = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               key_n,
  input  logic               activity,
  output logic [NFIELDS-1:0] sel,
  output logic [NFIELDS-1:0] disp_en,
  output logic               run_en,
  output logic               editing
);

  localparam int unsigned HOLD_C  = ms_to_cycles(CLK_HZ, HOLD_MS);
  localparam int unsigned FLASH_C = ms_to_cycles(CLK_HZ, FLASH_MS);
  localparam int unsigned OFF_C   = ms_to_cycles(CLK_HZ, OFF_MS);
  localparam int unsigned TMO_C   = CLK_HZ * TIMEOUT_S;

  localparam int unsigned HW = cnt_width(HOLD_C);
  localparam int unsigned FW = cnt_width(FLASH_C);
  localparam int unsigned TW = cnt_width(TMO_C);
  localparam int unsigned IW = cnt_width(NFIELDS);

  localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_C - 1);
  localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_C - 1);
  localparam logic [FW-1:0] OFF_START  = FW'(OFF_C);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TMO_C - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NFIELDS - 1);

  logic key_level, key_press;

  key_sync_edge u_key (
    .clk     (clk),
    .reset   (reset),
    .key_n_i (key_n),
    .level_o (key_level),
    .press_o (key_press)
  );

  state_e              state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [HW-1:0]       hold_q, hold_d;
  logic [FW-1:0]       phase_q, phase_d;
  logic [TW-1:0]       tmo_q, tmo_d;
  logic [NFIELDS-1:0]  sel_q, sel_d, disp_en_q, disp_en_d;
  logic                run_en_q, run_en_d, editing_q, editing_d;

  always_comb begin
    // NOTE: every variable gets a default first, so no path through the case
    // leaves one unassigned and no latch is inferred.
    state_d = state_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    phase_d = '0;
    tmo_d   = '0;

    unique case (state_q)
      ST_RUN: begin
        if (!key_level) begin
          state_d = ST_ARM;
          hold_d  = '0;
        end
      end
      ST_ARM: begin
        if (key_level)                state_d = ST_RUN;
        else if (hold_q == HOLD_LAST) state_d = ST_REL;
        else                          hold_d  = hold_q + 1'b1;
      end
      ST_REL: begin
        if (key_level) begin
          state_d = ST_EDIT;
          idx_d   = '0;
        end
      end
      ST_EDIT: begin
        // A press outranks both activity and timeout expiry; the new field
        // starts its flash period from the blank portion.
        if (key_press) begin
          if (idx_q == IDX_LAST) state_d = ST_RUN;
          else                   idx_d   = idx_q + 1'b1;
        end else if (activity) begin
          phase_d = OFF_START;
        end else if (TIMEOUT_S != 0 && tmo_q == TMO_LAST) begin
          state_d = ST_RUN;
        end else begin
          tmo_d   = (TIMEOUT_S != 0) ? tmo_q + 1'b1 : '0;
          phase_d = (phase_q == FLASH_LAST) ? '0 : phase_q + 1'b1;
        end
      end
      default: state_d = ST_RUN;
    endcase

    sel_d     = '0;
    disp_en_d = '1;
    run_en_d  = (state_d == ST_RUN);
    editing_d = (state_d == ST_EDIT);
    if (state_d == ST_EDIT) begin
      sel_d = NFIELDS'(1) << idx_d;
      if (phase_d < OFF_START) disp_en_d = ~(NFIELDS'(1) << idx_d);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_RUN;
      idx_q     <= '0;
      hold_q    <= '0;
      phase_q   <= '0;
      tmo_q     <= '0;
      sel_q     <= '0;
      disp_en_q <= '1;
      run_en_q  <= 1'b1;
      editing_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      hold_q    <= hold_d;
      phase_q   <= phase_d;
      tmo_q     <= tmo_d;
      sel_q     <= sel_d;
      disp_en_q <= disp_en_d;
      run_en_q  <= run_en_d;
      editing_q <= editing_d;
    end
  end

  assign sel     = sel_q;
  assign disp_en = disp_en_q;
  assign run_en  = run_en_q;
  assign editing = editing_q;

endmodule
